// File: rtl/dump_fmt_pkg.sv
// ---------------------------------------------------------------------------
// dump_fmt_pkg
// Constants and types shared by the dump hex formatter.
//   - ASCII codes for the separator, line terminator and hex digit bases.
//   - state_t: the 3-bit FSM encoding (IDLE, HI, LO, SEP, CR, LF).
//   - cnt_width(): width of a counter that has to hold 0..n-1, minimum 1 bit.
// ---------------------------------------------------------------------------
package dump_fmt_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        SEP  = 3'd3,
        CR   = 3'd4,
        LF   = 3'd5
    } state_t;

    // $clog2(1) is 0, which would give a zero-width counter; clamp to 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// ---------------------------------------------------------------------------
// hex_nibble_to_ascii
// Purely combinational map from a 4-bit value to its uppercase ASCII hex
// digit: 0x0-0x9 -> '0'-'9' (0x30-0x39), 0xA-0xF -> 'A'-'F' (0x41-0x46).
// Ports:
//   nibble  in   4  value to convert
//   ascii   out  8  ASCII character
// ---------------------------------------------------------------------------
module hex_nibble_to_ascii
    import dump_fmt_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Sixteen-entry constant table built at elaboration; the lookup itself
    // reduces to a small mux.
    logic [7:0] lut [16];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lut
            if (gi < 10) begin : g_digit
                assign lut[gi] = ASCII_0 + 8'(gi);
            end else begin : g_letter
                assign lut[gi] = ASCII_A + 8'(gi - 10);
            end
        end
    endgenerate

    assign ascii = lut[nibble];

endmodule

// File: rtl/dump_hex_formatter.sv
// ---------------------------------------------------------------------------
// dump_hex_formatter
// Turns the snooper's binary dump stream into printable hex text. Each byte
// becomes two uppercase hex characters; a space follows every
// BYTES_PER_GROUP bytes, and CR LF ends a line after BYTES_PER_LINE bytes or
// after a byte flagged as the last of a record. A line end suppresses the
// group space that would otherwise fall at the same point.
//
// Parameters:
//   BYTES_PER_LINE   bytes per text line (>= 1)
//   BYTES_PER_GROUP  bytes between spaces (1 .. BYTES_PER_LINE)
// Ports:
//   comm_clock  in   1   clock
//   reset       in   1   synchronous, active-high
//   in_valid    in   1   input byte available
//   in_ready    out  1   high only while idle
//   in_data     in   8   raw dump byte
//   in_last     in   1   byte ends a record (forces CR LF after it)
//   out_valid   out  1   registered, ASCII character available
//   out_ready   in   1   downstream accepts the character
//   out_data    out  8   registered ASCII character
//   line_count  out  16  completed lines since reset, wraps
// ---------------------------------------------------------------------------
module dump_hex_formatter
    import dump_fmt_pkg::*;
#(
    parameter int BYTES_PER_LINE  = 16,
    parameter int BYTES_PER_GROUP = 4
) (
    input  logic        comm_clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [15:0] line_count
);

    localparam int BCW = cnt_width(BYTES_PER_LINE);
    localparam int GCW = cnt_width(BYTES_PER_GROUP);

    localparam logic [BCW-1:0] LINE_LAST  = BCW'(BYTES_PER_LINE - 1);
    localparam logic [GCW-1:0] GROUP_LAST = GCW'(BYTES_PER_GROUP - 1);

    state_t           state_reg;
    logic [3:0]       lo_nibble_reg;
    logic             last_reg;
    logic [BCW-1:0]   byte_cnt_reg;
    logic [GCW-1:0]   group_cnt_reg;
    logic [15:0]      line_count_reg;
    logic             out_valid_reg;
    logic [7:0]       out_data_reg;

    logic [3:0]       nibble_sel;
    logic [7:0]       nibble_ascii;

    // The high nibble's character is loaded into out_data on the accept
    // edge, straight from in_data, so only the low nibble has to be kept
    // for the following LO character.
    assign nibble_sel = (state_reg == IDLE) ? in_data[7:4] : lo_nibble_reg;

    hex_nibble_to_ascii u_hex (
        .nibble (nibble_sel),
        .ascii  (nibble_ascii)
    );

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign line_count = line_count_reg;

    // Every output is computed one edge ahead of the state that presents
    // it, so out_valid/out_data come straight from flops and only change
    // when the current character has been taken (or on accept from IDLE).
    always_ff @(posedge comm_clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            lo_nibble_reg  <= 4'h0;
            last_reg       <= 1'b0;
            byte_cnt_reg   <= '0;
            group_cnt_reg  <= '0;
            line_count_reg <= 16'h0000;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        lo_nibble_reg <= in_data[3:0];
                        last_reg      <= in_last;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= nibble_ascii;
                        state_reg     <= HI;
                    end
                end

                HI: begin
                    if (out_ready) begin
                        out_data_reg <= nibble_ascii;
                        state_reg    <= LO;
                    end
                end

                LO: begin
                    if (out_ready) begin
                        byte_cnt_reg <= byte_cnt_reg + BCW'(1);
                        if (group_cnt_reg == GROUP_LAST) begin
                            group_cnt_reg <= '0;
                        end else begin
                            group_cnt_reg <= group_cnt_reg + GCW'(1);
                        end

                        // Line end is checked first so a group boundary that
                        // coincides with it never leaves a trailing space.
                        if (last_reg || (byte_cnt_reg == LINE_LAST)) begin
                            out_data_reg <= ASCII_CR;
                            state_reg    <= CR;
                        end else if (group_cnt_reg == GROUP_LAST) begin
                            out_data_reg <= ASCII_SPACE;
                            state_reg    <= SEP;
                        end else begin
                            out_valid_reg <= 1'b0;
                            out_data_reg  <= 8'h00;
                            state_reg     <= IDLE;
                        end
                    end
                end

                SEP: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_data_reg  <= 8'h00;
                        state_reg     <= IDLE;
                    end
                end

                CR: begin
                    if (out_ready) begin
                        out_data_reg <= ASCII_LF;
                        state_reg    <= LF;
                    end
                end

                LF: begin
                    if (out_ready) begin
                        // Counters restart here rather than in LO so that a
                        // short (in_last) line also starts the next line clean.
                        byte_cnt_reg   <= '0;
                        group_cnt_reg  <= '0;
                        line_count_reg <= line_count_reg + 16'd1;
                        out_valid_reg  <= 1'b0;
                        out_data_reg   <= 8'h00;
                        state_reg      <= IDLE;
                    end
                end

                default: begin
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= 8'h00;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule
